// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared widths and FSM state type for the load/store unit
package lsu_pkg;

  localparam int DEF_WORDSIZE = 64;
  localparam int DEF_SIZE     = 32;
  localparam int DEF_ADDR_W   = $clog2(DEF_SIZE);
  localparam int DEF_OFFSET_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_agu.sv
// rtl/lsu_agu.sv - effective address adder; range fault under LSU_RANGE_CHECK_EN
module lsu_agu
  import lsu_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter int SIZE     = DEF_SIZE,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic [WORDSIZE-1:0] base,
  input  logic [OFFSET_W-1:0] offset,
  output logic [WORDSIZE-1:0] ea,
  output logic                fault
);

  logic [WORDSIZE-1:0] offset_sext;

  // Sign-extend the offset and add modulo 2^WORDSIZE; negative results wrap high.
  always_comb begin
    offset_sext = {{(WORDSIZE-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    ea          = base + offset_sext;
  end

`ifdef LSU_RANGE_CHECK_EN
  // Full-width unsigned compare so wrapped negative addresses also fault.
  assign fault = (ea >= WORDSIZE'(SIZE));
`else
  assign fault = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store front end (option: LSU_RANGE_CHECK_EN)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter int SIZE     = DEF_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [WORDSIZE-1:0] req_base,
  input  logic [OFFSET_W-1:0] req_offset,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_fault,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  output logic                mem_write_enable,
  output logic                mem_read,
  input  logic [WORDSIZE-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                store_q, store_d;
  logic                fault_q, fault_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORDSIZE-1:0] wdata_q, wdata_d;
  logic [WORDSIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic                resp_fault_q, resp_fault_d;

  logic [WORDSIZE-1:0] agu_ea;
  logic                agu_fault;
  logic                in_access;
  logic                unused_ea_hi;

  lsu_agu #(
    .WORDSIZE (WORDSIZE),
    .SIZE     (SIZE),
    .OFFSET_W (OFFSET_W)
  ) u_agu (
    .base   (req_base),
    .offset (req_offset),
    .ea     (agu_ea),
    .fault  (agu_fault)
  );

  // Only the low address bits reach the memory; the rest feed the fault check.
  assign unused_ea_hi = ^agu_ea[WORDSIZE-1:ADDR_W];

  // Next-state and latch logic for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    fault_d      = fault_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
          store_d = req_store;
          fault_d = agu_fault;
          addr_d  = agu_ea[ADDR_W-1:0];
          wdata_d = req_wdata;
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_fault_d = fault_q;
        resp_rdata_d = (!store_q && !fault_q) ? mem_rdata : '0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latches and response register; reset discards any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      fault_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      fault_q      <= fault_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Memory strobes exist only in ACCESS; write enable also drops with reset itself.
  always_comb begin
    in_access        = (state_q == ACCESS);
    mem_addr         = in_access ? addr_q : '0;
    mem_wdata        = (in_access && store_q && !fault_q) ? wdata_q : '0;
    mem_write_enable = in_access && store_q && !fault_q && !reset;
    mem_read         = in_access && !store_q && !fault_q;
    req_ready        = (state_q == IDLE);
    resp_valid       = (state_q == RESP);
    resp_rdata       = resp_rdata_q;
    resp_fault       = resp_fault_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [63:0] req_base;
  logic [11:0] req_offset;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [4:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write_enable;
  logic        mem_read;
  logic [63:0] mem_rdata;

  logic [63:0] mem [32];
  logic [63:0] model [32];
  logic        init_en;

  typedef struct packed {
    logic [63:0] rdata;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;

  load_store_unit dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_base         (req_base),
    .req_offset       (req_offset),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_write_enable (mem_write_enable),
    .mem_read         (mem_read),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
    end else if (mem_write_enable) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check the ACCESS cycle, push the expected response, stop in RESP.
  task automatic do_access(input string tag, input logic st, input logic [63:0] base,
                           input logic [11:0] off, input logic [63:0] wd, input logic keep);
    logic [63:0] ea;
    logic        flt;
    logic [4:0]  a;
    exp_t        e;
    ea = base + {{52{off[11]}}, off};
`ifdef LSU_RANGE_CHECK_EN
    flt = (ea >= 64'd32);
`else
    flt = 1'b0;
`endif
    a = ea[4:0];
    req_store  = st;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    req_valid  = 1'b1;
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    tick();
    if (!keep) req_valid = 1'b0;
    check({tag, "_addr"}, 64'(mem_addr), 64'(a));
    check({tag, "_we"}, 64'(mem_write_enable), 64'(st && !flt));
    check({tag, "_rd"}, 64'(mem_read), 64'(!st && !flt));
    check({tag, "_busy"}, 64'(req_ready), 64'd0);
    e.rdata = (st || flt) ? 64'd0 : model[a];
    e.fault = flt;
    exp_q.push_back(e);
    if (st && !flt) model[a] = wd;
    tick();
  endtask

  // Wait (bounded) for the response, compare against the scoreboard, then hand it off.
  task automatic finish_resp(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!resp_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(resp_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'(exp_q.size()));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_fault"}, 64'(resp_fault), 64'(e.fault));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_done"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    exp_t        e;
    for (int i = 0; i < 32; i++) model[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    init_en    = 1'b1;
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_base   = 64'd7;
    req_offset = 12'd0;
    req_wdata  = 64'h1234;
    resp_ready = 1'b0;

    // Reset held with a request pending.
    tick();
    tick();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_fault", 64'(resp_fault), 64'd0);
    check("rst_we", 64'(mem_write_enable), 64'd0);
    check("rst_rd", 64'(mem_read), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    reset     = 1'b0;
    req_valid = 1'b0;
    init_en   = 1'b0;
    check("rst_rel_ready", 64'(req_ready), 64'd1);
    tick();
    check("rst_no_access", 64'(mem_write_enable | mem_read), 64'd0);
    check("rst_mem7", mem[7], model[7]);

    // Store then load back.
    do_access("st7", 1'b1, 64'd4, 12'd3, 64'hDEAD, 1'b0);
    finish_resp("st7");
    check("st7_mem", mem[7], 64'hDEAD);
    do_access("ld7", 1'b0, 64'd7, 12'd0, 64'd0, 1'b0);
    finish_resp("ld7");

    // Negative offset.
    do_access("neg", 1'b0, 64'd10, 12'hFFE, 64'd0, 1'b0);
    finish_resp("neg");

    // Backpressure with a second request held on the input.
    do_access("bp", 1'b0, 64'd4, 12'd3, 64'd0, 1'b1);
    held = resp_rdata;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_rdata", resp_rdata, held);
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_noacc", 64'(mem_read | mem_write_enable), 64'd0);
      tick();
    end
    e = exp_q.pop_front();
    check("bp_rdata_exp", resp_rdata, e.rdata);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_idle_valid", 64'(resp_valid), 64'd0);
    check("bp_idle_ready", 64'(req_ready), 64'd1);
    check("bp_idle_noacc", 64'(mem_read), 64'd0);
    tick();
    req_valid = 1'b0;
    check("bp2_rd", 64'(mem_read), 64'd1);
    check("bp2_addr", 64'(mem_addr), 64'd7);
    e.rdata = model[7];
    e.fault = 1'b0;
    exp_q.push_back(e);
    tick();
    finish_resp("bp2");

    // Out-of-range store: faults with the check, wraps to word 3 without it.
    do_access("rng", 1'b1, 64'd30, 12'd5, 64'h55, 1'b0);
    finish_resp("rng");
`ifdef LSU_RANGE_CHECK_EN
    check("rng_mem3", mem[3], 64'hA5A5_0000_0000_0003);
`else
    check("rng_mem3", mem[3], 64'h55);
`endif
    do_access("rng_ld", 1'b0, 64'd3, 12'd0, 64'd0, 1'b0);
    finish_resp("rng_ld");

    // Reset mid-ACCESS of a store to word 9.
    req_store  = 1'b1;
    req_base   = 64'd9;
    req_offset = 12'd0;
    req_wdata  = 64'h77;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rsta_we_pre", 64'(mem_write_enable), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("rsta_we", 64'(mem_write_enable), 64'd0);
    check("rsta_ready", 64'(req_ready), 64'd1);
    check("rsta_valid", 64'(resp_valid), 64'd0);
    tick();
    check("rsta_mem9", mem[9], model[9]);
    reset = 1'b0;
    tick();
    check("rsta_valid2", 64'(resp_valid), 64'd0);
    check("rsta_ready2", 64'(req_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store front end that sits directly upstream of the processor's data memory (64-bit words, 32 entries, combinational read, write on rising clock edge). It accepts one load or store request at a time over a valid/ready handshake and computes the effective word address as base plus sign-extended offset. It drives the memory's address, data, write-enable and read lines for exactly one cycle, then returns the load data, or a store acknowledge, over a valid/ready response channel.

## Interface
- WORDSIZE, 64, data word width; must match the data memory.
- SIZE, 32, number of memory words; must be a power of two.
- ADDR_W, 5, memory address width, equal to $clog2(SIZE).
- OFFSET_W, 12, width of the signed request offset.

- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_base  in  WORDSIZE  base word address, unsigned.
- req_offset  in  OFFSET_W  signed word offset.
- req_wdata  in  WORDSIZE  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  WORDSIZE  load data; 0 for stores and faults.
- resp_fault  out  1  address out of range; constant 0 when the range check is compiled out.
- mem_addr  out  ADDR_W  to the memory's address input.
- mem_wdata  out  WORDSIZE  to the memory's write-data input.
- mem_write_enable  out  1  to the memory's write enable.
- mem_read  out  1  to the memory's read enable.
- mem_rdata  in  WORDSIZE  from the memory's read-data output.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_store, req_wdata and the effective address ea, plus the fault flag; go to ACCESS.
- ACCESS: lasts exactly one cycle.
  - mem_addr = ea[ADDR_W-1:0].
  - Store without fault: mem_write_enable = 1, mem_wdata = the latched data.
  - Load without fault: mem_read = 1. mem_rdata is captured into resp_rdata at the closing edge.
  - Fault: both enables stay 0 and resp_rdata = 0.
  - Go to RESP.
- RESP:
  - resp_valid = 1. resp_rdata and resp_fault are held stable.
  - On resp_ready, go to IDLE.
- Outside ACCESS:
  - mem_addr, mem_wdata, mem_write_enable and mem_read are all 0.
  - req_ready = 0 in ACCESS and RESP, so requests arriving then are not accepted.
- Arithmetic:
  - ea = req_base + sign_extend(req_offset) modulo 2^WORDSIZE.
  - A negative result wraps to a large unsigned value.
- Read-after-write: the write commits at the edge that ends ACCESS, so any later load returns the new data.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, all mem_* outputs 0.
- Reset mid-operation:
  - The FSM clears asynchronously.
  - A store in ACCESS whose closing edge is reached while reset is high does not write, because mem_write_enable falls combinationally with reset.
  - Any pending response is discarded.
- Latency:
  - Request accepted at edge N.
  - ACCESS during cycle N to N+1.
  - resp_valid high from edge N+1.
- Throughput: with resp_ready held high, one request every 3 cycles.
- Backpressure: while resp_ready is low, all response outputs are held unchanged for as long as needed.
- Simultaneous req_valid and a response handshake in RESP: the request is not accepted until the following IDLE cycle.

## Configuration
- Macro: LSU_RANGE_CHECK_EN.
- Defined:
  - resp_fault = 1 when ea >= SIZE (unsigned comparison on the full WORDSIZE bits).
  - A faulting request performs no memory access and returns resp_rdata = 0.
- Undefined:
  - There is no check; ea is truncated to ADDR_W bits, so the address wraps modulo SIZE.
  - resp_fault is tied to 0.

## Structure
- Package lsu_pkg:
  - state enum (IDLE, ACCESS, RESP);
  - default widths for WORDSIZE, SIZE, ADDR_W and OFFSET_W.
- One sub-module, lsu_agu, purely combinational:
  - sign-extends the offset and performs the WORDSIZE-bit add;
  - outputs ea and, under LSU_RANGE_CHECK_EN, the fault flag.
- The FSM, request latches and response register live in load_store_unit.

## Test plan
- Reset:
  - Stimulus: pulse reset with req_valid high.
  - Required: every output at its reset value, req_ready = 1 after release, no memory access.
- Store then load:
  - Stimulus: store with base 4, offset 3, data 0xDEAD.
  - Required, ACCESS cycle: mem_addr = 7, mem_write_enable = 1.
  - Required, response: resp_rdata = 0, resp_fault = 0.
  - Stimulus: load with base 7, offset 0.
  - Required: mem_read = 1 in ACCESS, resp_rdata = 0xDEAD.
- Negative offset:
  - Stimulus: load with base 10, offset -2.
  - Required: mem_addr = 8 and the word at address 8 is returned.
- Backpressure:
  - Stimulus: hold resp_ready = 0 for 5 cycles with req_valid held high.
  - Required: resp_valid and resp_rdata stable, req_ready = 0, no second request accepted.
  - Required on release: next ACCESS starts 2 cycles after the response handshake.
- Range check:
  - Stimulus: store with base 30, offset 5, data 0x55.
  - Required with LSU_RANGE_CHECK_EN: resp_fault = 1 and word 3 unchanged.
  - Required without it: word 3 = 0x55 (35 mod 32) and resp_fault = 0.
- Reset during ACCESS:
  - Stimulus: assert reset mid-cycle while a store of 0x77 to address 9 is in ACCESS.
  - Required: word 9 unchanged, FSM back in IDLE, resp_valid = 0.
